// File: rtl/score_keeper.sv
// score_keeper
//   Two-player score accumulator sitting behind the per-player point counters.
//   Each point line is edge-detected, so a level held high scores once. A
//   scored point either ends the game (score hits WIN_SCORE) or triggers a
//   one-cycle RoundRestart so the playfield re-centres. After a win the block
//   stays locked in OVER until Reset.
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   synchronous active-high reset
//   LeftPoint    in   left player point level
//   RightPoint   in   right player point level
//   LeftScore    out  [SCORE_W-1:0] registered left score
//   RightScore   out  [SCORE_W-1:0] registered right score
//   HexLeft      out  [6:0] active-low {g..a} segments for LeftScore
//   HexRight     out  [6:0] active-low {g..a} segments for RightScore
//   RoundRestart out  one-cycle pulse after a non-winning point
//   GameOver     out  high while the game is locked
//   Winner       out  [1:0] 00 none, 01 left, 10 right
module score_keeper #(
    parameter int SCORE_W   = 3,
    parameter int WIN_SCORE = 7
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               LeftPoint,
    input  logic               RightPoint,
    output logic [SCORE_W-1:0] LeftScore,
    output logic [SCORE_W-1:0] RightScore,
    output logic [6:0]         HexLeft,
    output logic [6:0]         HexRight,
    output logic               RoundRestart,
    output logic               GameOver,
    output logic [1:0]         Winner
);

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {PLAY, RESTART, OVER} state_t;

    state_t             state, state_nxt;
    logic               prevl, prevr;
    logic               risel, riser;
    logic [SCORE_W-1:0] left_nxt, right_nxt;
    logic [1:0]         winner_nxt;

    // History resets high so a line already asserted during reset is not
    // mistaken for a fresh point when reset releases.
    assign risel = LeftPoint  & ~prevl;
    assign riser = RightPoint & ~prevr;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= PLAY;
            prevl      <= 1'b1;
            prevr      <= 1'b1;
            LeftScore  <= '0;
            RightScore <= '0;
            Winner     <= 2'b00;
        end else begin
            state      <= state_nxt;
            prevl      <= LeftPoint;
            prevr      <= RightPoint;
            LeftScore  <= left_nxt;
            RightScore <= right_nxt;
            Winner     <= winner_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        left_nxt   = LeftScore;
        right_nxt  = RightScore;
        winner_nxt = Winner;
        case (state)
            PLAY: begin
                // Simultaneous rises are a tie and are dropped entirely.
                if (risel && !riser) begin
                    left_nxt = LeftScore + 1'b1;
                    if (left_nxt == WIN_VAL) begin
                        state_nxt  = OVER;
                        winner_nxt = 2'b01;
                    end else begin
                        state_nxt = RESTART;
                    end
                end else if (riser && !risel) begin
                    right_nxt = RightScore + 1'b1;
                    if (right_nxt == WIN_VAL) begin
                        state_nxt  = OVER;
                        winner_nxt = 2'b10;
                    end else begin
                        state_nxt = RESTART;
                    end
                end
            end
            RESTART: state_nxt = PLAY;
            OVER:    state_nxt = OVER;
            default: state_nxt = PLAY;
        endcase
    end

    // Status outputs decode straight from the state register: glitch-free.
    assign RoundRestart = (state == RESTART);
    assign GameOver     = (state == OVER);

    function automatic logic [6:0] seg7(input logic [SCORE_W-1:0] v);
        logic [6:0] s;
        case (32'(v))
            32'd0:   s = 7'b1000000;
            32'd1:   s = 7'b1111001;
            32'd2:   s = 7'b0100100;
            32'd3:   s = 7'b0110000;
            32'd4:   s = 7'b0011001;
            32'd5:   s = 7'b0010010;
            32'd6:   s = 7'b0000010;
            32'd7:   s = 7'b1111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign HexLeft  = seg7(LeftScore);
    assign HexRight = seg7(RightScore);

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: each driven cycle pushes the behavioural
// model's expected outputs, which are popped and compared after the edge.
module tb_score_keeper;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       LeftPoint = 1'b0;
    logic       RightPoint = 1'b0;
    logic [2:0] LeftScore, RightScore;
    logic [6:0] HexLeft, HexRight;
    logic       RoundRestart, GameOver;
    logic [1:0] Winner;

    score_keeper #(.SCORE_W(3), .WIN_SCORE(7)) dut (
        .Clock(Clock), .Reset(Reset),
        .LeftPoint(LeftPoint), .RightPoint(RightPoint),
        .LeftScore(LeftScore), .RightScore(RightScore),
        .HexLeft(HexLeft), .HexRight(HexRight),
        .RoundRestart(RoundRestart), .GameOver(GameOver), .Winner(Winner)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int         ls, rs;
        logic [6:0] hl, hr;
        logic       rr, go;
        logic [1:0] win;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;

    // model state: 0 play, 1 restart, 2 over
    int   mst = 0, ml = 0, mr = 0;
    logic mpl = 1'b1, mpr = 1'b1;
    logic [1:0] mwin = 2'b00;
    logic [6:0] segtab [0:7] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        nvec++;
        if (obs !== expv) begin
            nerr++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic l, input logic r);
        logic rl, rrise;
        if (rst) begin
            mst = 0; ml = 0; mr = 0; mwin = 2'b00; mpl = 1'b1; mpr = 1'b1;
        end else begin
            rl    = l & ~mpl;
            rrise = r & ~mpr;
            if (mst == 0) begin
                if (rl && !rrise) begin
                    ml++;
                    if (ml == 7) begin mst = 2; mwin = 2'b01; end else mst = 1;
                end else if (rrise && !rl) begin
                    mr++;
                    if (mr == 7) begin mst = 2; mwin = 2'b10; end else mst = 1;
                end
            end else if (mst == 1) begin
                mst = 0;
            end
            mpl = l; mpr = r;
        end
    endtask

    task automatic step(input logic rst, input logic l, input logic r);
        exp_t e;
        @(negedge Clock);
        Reset = rst; LeftPoint = l; RightPoint = r;
        model_edge(rst, l, r);
        e.ls = ml; e.rs = mr; e.hl = segtab[ml]; e.hr = segtab[mr];
        e.rr = (mst == 1); e.go = (mst == 2); e.win = mwin;
        sbq.push_back(e);
        @(posedge Clock);
        #1;
        e = sbq.pop_front();
        chk("LeftScore",    8'(LeftScore),    8'(e.ls));
        chk("RightScore",   8'(RightScore),   8'(e.rs));
        chk("HexLeft",      8'(HexLeft),      8'(e.hl));
        chk("HexRight",     8'(HexRight),     8'(e.hr));
        chk("RoundRestart", 8'(RoundRestart), 8'(e.rr));
        chk("GameOver",     8'(GameOver),     8'(e.go));
        chk("Winner",       8'(Winner),       8'(e.win));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rr_cnt;
        // reset with LeftPoint high, then hold it high
        step(1, 1, 0); step(1, 1, 0);
        rr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0);
            rr_cnt += int'(RoundRestart);
        end
        chk("held_high_score", 8'(LeftScore), 8'd0);
        chk("held_high_hex",   8'(HexLeft),   8'b01000000);
        chk("held_high_rr",    8'(rr_cnt),    8'd0);

        // RightPoint high for 3 cycles
        step(0, 0, 0);
        rr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            rr_cnt += int'(RoundRestart);
        end
        step(0, 0, 0);
        chk("r1_score",  8'(RightScore), 8'd1);
        chk("r1_hex",    8'(HexRight),   8'b01111001);
        chk("r1_rr_len", 8'(rr_cnt),     8'd1);

        // a rise landing in the RESTART cycle is dropped
        step(0, 1, 0);            // left scores -> RESTART
        step(0, 1, 1);            // right rises during RESTART
        chk("restart_rr", 8'(RoundRestart), 8'd0);
        step(0, 0, 0); step(0, 0, 0);
        chk("restart_ignored", 8'(RightScore), 8'd1);
        step(0, 0, 1); step(0, 0, 0);   // fresh rise
        chk("fresh_rise", 8'(RightScore), 8'd2);
        step(0, 0, 0);

        // simultaneous rise: tie ignored
        step(0, 1, 1);
        chk("tie_rr", 8'(RoundRestart), 8'd0);
        chk("tie_l",  8'(LeftScore),    8'd1);
        chk("tie_r",  8'(RightScore),   8'd2);
        step(0, 0, 0);

        // left up to 7
        while (ml < 7) begin
            step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
        end
        chk("win_score", 8'(LeftScore),  8'd7);
        chk("win_hex",   8'(HexLeft),    8'b01111000);
        chk("win_go",    8'(GameOver),   8'd1);
        chk("win_who",   8'(Winner),     8'b01);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0); step(0, 0, 1); step(0, 0, 0);
        end
        chk("over_frozen_l", 8'(LeftScore),  8'd7);
        chk("over_frozen_r", 8'(RightScore), 8'd2);

        // reset while OVER
        step(1, 0, 0);
        chk("rst_over_go", 8'(GameOver),  8'd0);
        chk("rst_over_l",  8'(LeftScore), 8'd0);
        step(0, 0, 0);
        // reset while RoundRestart is high
        step(0, 1, 0);
        chk("pre_rst_rr", 8'(RoundRestart), 8'd1);
        step(1, 0, 0);
        chk("rst_rr_rr", 8'(RoundRestart), 8'd0);
        chk("rst_rr_l",  8'(LeftScore),    8'd0);
        step(0, 0, 0);

        // random traffic, both players racing, occasional reset
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom));

        if (sbq.size() != 0) chk("sb_empty", 8'(sbq.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Downstream consumer of the per-player point counters in the two-player game datapath.
- Edge-detects each player's point/Increase line and accumulates a 3-bit score per player.
- Drives two active-low seven-segment digits, declares a winner at WIN_SCORE, and pulses a round-restart back to the playfield logic.
- Holds the game locked after victory until Reset.

Parameters:
- SCORE_W, 3, width of each score register.
- WIN_SCORE, 7, score value that ends the game; must be 1..(2^SCORE_W - 1).

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- LeftPoint  input  1  left player point level from the upstream counter; may stay high for many cycles.
- RightPoint  input  1  right player point level; same rules as LeftPoint.
- LeftScore  output  SCORE_W  left player's registered score.
- RightScore  output  SCORE_W  right player's registered score.
- HexLeft  output  7  active-low segments {g,f,e,d,c,b,a} showing LeftScore.
- HexRight  output  7  active-low segments showing RightScore.
- RoundRestart  output  1  one-cycle pulse telling upstream to re-centre and clear for the next round.
- GameOver  output  1  high while in OVER.
- Winner  output  2  00 none, 01 left, 10 right; 11 never driven.

Behaviour:
- Clock and reset
  - Single clock. Reset is synchronous, active-high, and overrides everything, including mid-round and in OVER.
- Reset values
  - LeftScore=0, RightScore=0, RoundRestart=0, GameOver=0, Winner=00, state=PLAY.
  - Edge-history registers prevL=1 and prevR=1, so an input already high during reset is not counted.
- Edge detection
  - riseL = LeftPoint & ~prevL; riseR = RightPoint & ~prevR.
  - prevL and prevR load the inputs on every edge, in every state.
  - A level held high counts exactly once.
- FSM states: PLAY, RESTART, OVER.
- PLAY
  - Exactly one of riseL/riseR set: that score increments at this edge.
  - If the incremented value == WIN_SCORE: go to OVER and set Winner at the same edge.
  - Otherwise: go to RESTART.
  - riseL and riseR in the same cycle: no score change, stay in PLAY (tie, ignored).
  - Neither set: hold.
- RESTART
  - Lasts exactly one cycle. RoundRestart=1 throughout; rises are ignored and not queued.
  - Always returns to PLAY.
- OVER
  - GameOver=1; Winner and scores frozen; rises ignored; no RoundRestart.
  - Exits only via Reset.
- Latency
  - A rising input sampled at edge k updates the score register at edge k, so the new value is visible after k.
  - RoundRestart is high from edge k to edge k+1.
  - GameOver and Winner are valid after edge k when the winning point lands.
- Arithmetic
  - Unsigned SCORE_W-bit values. A score never exceeds WIN_SCORE, so no wrap can occur.
- Seven-segment decode (combinational from the score registers, active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - Values above 7 (only possible when SCORE_W>3) show all segments off (1111111).
- Outputs are glitch-free. Scores, RoundRestart, GameOver and Winner are registered or decoded from state only.

Test Plan:
- Reset with LeftPoint held high, then release Reset and keep LeftPoint high for 10 cycles -> LeftScore stays 0, HexLeft=1000000, no RoundRestart.
- From reset, pulse RightPoint high for 3 cycles -> RightScore=1 after the first rising edge, HexRight=1111001, RoundRestart high exactly one cycle, state back to PLAY.
- Second RightPoint rise arriving during the RESTART cycle -> ignored, RightScore stays 1. A fresh rise after RESTART -> RightScore=2.
- LeftPoint and RightPoint rise in the same cycle -> both scores unchanged, RoundRestart stays 0.
- Seven separate LeftPoint rises, each spaced ≥3 cycles -> LeftScore steps 1..7, HexLeft=1111000 at 7.
  - GameOver=1 and Winner=01 after the 7th rise, with no RoundRestart on that point.
  - Further rises on either input -> no change.
- Assert Reset for one cycle while in OVER, and separately while RoundRestart=1 -> all outputs return to reset values on the next edge, state=PLAY.
